// File: rtl/mem_responder.sv
// mem_responder: memory request responder; alignment check, one valid/ready bus transaction,
// store lane steering and sign/zero-extended load extraction.
module mem_responder #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en_mem,
   input  logic [1:0]  W_R_mem,
   input  logic [1:0]  wordsize_mem,
   input  logic        sign_mem,
   input  logic [31:0] inst_addr,
   input  logic [31:0] data_addr,
   input  logic [31:0] wdata,
   output logic        busy_mem,
   output logic        done_mem,
   output logic        aligned_mem,
   output logic [31:0] rdata,
   output logic        err_timeout,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic        mem_instr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata
);
   localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2, ERR = 2'd3;
   logic [1:0]  state_q, state_d, size, lane, size_q, lane_q;
   logic        fetch, reserved, misaligned, accept, timeout, sign_q, instr_q, err_q;
   logic [31:0] addr, cnt_q, addr_q, wdata_q, rdata_q, ld;
   logic [3:0]  wstrb_q;
   logic [15:0] half;
   logic [7:0]  byte_v;
   always_comb begin
      fetch      = W_R_mem == 2'b11;
      reserved   = W_R_mem == 2'b10;
      size       = fetch ? 2'b10 : wordsize_mem;
      addr       = fetch ? inst_addr : data_addr;
      lane       = addr[1:0];
      misaligned = size == 2'b11 || (size == 2'b01 && lane[0]) || (size == 2'b10 && lane != 2'b00);
      accept     = en_mem && (state_q == IDLE || state_q == ERR);
      timeout    = TIMEOUT_CYCLES != 0 && cnt_q == TIMEOUT_CYCLES - 1;
      state_d    = accept ? (reserved ? DONE : misaligned ? ERR : REQ) :
                   state_q == REQ  ? (mem_ready ? DONE : timeout ? IDLE : REQ) :
                   state_q == DONE ? IDLE : state_q;
      half       = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      byte_v     = mem_rdata[{lane_q, 3'b000} +: 8];
      ld         = size_q == 2'b00 ? {{24{sign_q & byte_v[7]}}, byte_v} :
                   size_q == 2'b01 ? {{16{sign_q & half[15]}}, half} : mem_rdata;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         size_q  <= '0;
         lane_q  <= '0;
         sign_q  <= 1'b0;
         instr_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= state_q == REQ && !mem_ready && timeout;
         // Counter idles at zero outside REQ, so every entry into REQ starts a fresh count.
         cnt_q   <= (state_q == REQ && !mem_ready) ? cnt_q + 32'd1 : '0;
         if (accept) begin
            size_q  <= size;
            lane_q  <= lane;
            sign_q  <= sign_mem && !fetch;
            instr_q <= fetch;
            addr_q  <= {addr[31:2], 2'b00};
            wdata_q <= size == 2'b00 ? {4{wdata[7:0]}} : size == 2'b01 ? {2{wdata[15:0]}} : wdata;
            wstrb_q <= W_R_mem != 2'b00 ? 4'b0000 : size == 2'b00 ? 4'b0001 << lane :
                       size == 2'b01 ? 4'b0011 << lane : 4'b1111;
         end
         if (state_q == REQ && mem_ready) rdata_q <= ld;
      end
   end
   assign busy_mem    = state_q == REQ;
   assign mem_valid   = state_q == REQ;
   assign done_mem    = state_q == DONE;
   assign aligned_mem = state_q != ERR;
   assign err_timeout = err_q;
   assign rdata       = rdata_q;
   assign mem_instr   = instr_q;
   assign mem_addr    = addr_q;
   assign mem_wdata   = wdata_q;
   assign mem_wstrb   = wstrb_q;
endmodule
